updown_counter_n: RTL
=====================

# updown_counter_n

Parametrised up/down counter for the counter/stimulus test designs. It generalises the fixed 8-bit up/down counter in four ways: configurable width, a programmable modulus, a variable step, and synchronous clear/load. It also reports wrap events and terminal-count flags. An optional saturating mode can be compiled in.

## Interface
Parameters:
- WIDTH, 8, counter and data width in bits (2..32)
- MAX_VAL, 2**WIDTH-1, highest count value; the counter runs modulo MAX_VAL+1; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1
- RESET_VAL, 0, count value after reset or clear; must be ≤ MAX_VAL

Ports:
- pi_bClk  in  1  clock; all state updates on the rising edge
- pi_bReset_n  in  1  reset, asynchronous, active-low
- pi_bClear  in  1  synchronous clear to RESET_VAL
- pi_bLoad  in  1  synchronous load of pi_Data
- pi_Data  in  WIDTH  load value
- pi_bEnable  in  1  count enable
- pi_bUpDown  in  1  direction: 0 = up, 1 = down
- pi_Step  in  WIDTH  increment/decrement amount
- pi_bSat  in  1  saturate select; present only with COUNTER_SATURATE_EN
- po_Count  out  WIDTH  current count, registered
- po_bWrap  out  1  one-cycle pulse when a count operation crossed a boundary
- po_bAtMax  out  1  po_Count == MAX_VAL (decode of the count register)
- po_bAtMin  out  1  po_Count == 0 (decode of the count register)

## Operation
- Priority per edge, highest first: reset, then clear, then load, then enabled count, then hold.
- Reset (pi_bReset_n=0, asynchronous): po_Count=RESET_VAL, po_bWrap=0.
- Clear: po_Count=RESET_VAL, po_bWrap=0.
- Load: po_Count=min(pi_Data, MAX_VAL), po_bWrap=0.
- Count: applies when pi_bEnable=1 and neither clear nor load is active.
  - Effective step s = min(pi_Step, MAX_VAL).
  - s=0: hold the count, po_bWrap=0.
  - Arithmetic uses WIDTH+1 bits; there is no intermediate overflow.
- Up, wrap mode:
  - n = cnt + s.
  - If n > MAX_VAL: cnt ← n − (MAX_VAL+1), po_bWrap=1.
  - Otherwise: cnt ← n.
- Down, wrap mode:
  - If s > cnt: cnt ← cnt + (MAX_VAL+1) − s, po_bWrap=1.
  - Otherwise: cnt ← cnt − s.
- Saturate mode (macro compiled in and pi_bSat=1):
  - Up clamps at MAX_VAL; down clamps at 0.
  - po_bWrap=1 whenever clamping occurred, including a further attempt while already at the limit.
- po_bWrap is 0 on every cycle that has no boundary event.
- pi_bUpDown, pi_Step and pi_bSat are sampled only on count edges.

## Timing
- Latency: one edge. Inputs sampled at edge k produce po_Count and po_bWrap valid after edge k.
- po_bAtMax and po_bAtMin follow po_Count in the same cycle; there is no additional register stage.
- Simultaneous clear+load+enable: clear wins. Load+enable: load wins, no count, no wrap.
- Reset mid-operation: outputs take reset values immediately, with no wait for the clock. The first update happens on the first rising edge after pi_bReset_n rises.
- MAX_VAL = 2**WIDTH-1 gives plain modulo-2^WIDTH behaviour.

## Configuration
- Macro: COUNTER_SATURATE_EN.
- Defined: the pi_bSat port exists. pi_bSat=1 selects saturate mode; pi_bSat=0 selects wrap mode.
- Undefined: the pi_bSat port and the saturation logic are absent, and the block always wraps.

## Test plan
Configuration for all scenarios: WIDTH=4, MAX_VAL=9, RESET_VAL=0.
- Reset: assert pi_bReset_n=0 between clock edges -> po_Count=0, po_bWrap=0 and po_bAtMin=1 before the next edge. Release, enable up with step 1 for 12 edges -> sequence 1..9,0,1,2, with po_bWrap=1 only in the cycle po_Count=0.
- Down wrap with step: load 2, then down with pi_Step=3 -> po_Count=9 (2+10−3), po_bWrap=1. Next edge -> 6, po_bWrap=0.
- Priority and clamp: clear+load(5)+enable in one cycle -> po_Count=0. Load alone with pi_Data=15 -> po_Count=9, po_bAtMax=1. pi_Step=12 up from 0 -> step clamps to 9, po_Count=9.
- Hold: pi_bEnable=0 or pi_Step=0 for 5 edges -> po_Count unchanged, po_bWrap stays 0.
- Saturate (COUNTER_SATURATE_EN defined, pi_bSat=1): load 8, up with step 3 -> po_Count=9, po_bWrap=1. Repeat -> still 9, po_bWrap=1. Down step 4 from 2 -> 0, po_bWrap=1. With pi_bSat=0 the wrap results above apply.

Source files
------------

// File: rtl/updown_counter_n.sv
// -----------------------------------------------------------------------------
// updown_counter_n
//
// Parametrised up/down counter with a programmable modulus, a variable step,
// synchronous clear and load, a one-cycle wrap/clamp pulse and terminal-count
// flags.
//
// Optional feature macro: COUNTER_SATURATE_EN
//   defined   -> adds pi_bSat; pi_bSat=1 clamps at the limits instead of
//                wrapping, pi_bSat=0 keeps the wrap behaviour.
//   undefined -> no pi_bSat port, the counter always wraps.
//
// Parameters:
//   WIDTH      counter/data width in bits (2..32)
//   MAX_VAL    highest count value; counting is modulo MAX_VAL+1
//   RESET_VAL  count value after reset or clear (<= MAX_VAL)
//
// Ports:
//   pi_bClk      in   clock, rising edge
//   pi_bReset_n  in   asynchronous active-low reset
//   pi_bClear    in   synchronous clear to RESET_VAL (highest sync priority)
//   pi_bLoad     in   synchronous load of min(pi_Data, MAX_VAL)
//   pi_Data      in   load value
//   pi_bEnable   in   count enable
//   pi_bUpDown   in   direction: 0 = up, 1 = down
//   pi_Step      in   step size (clamped to MAX_VAL)
//   pi_bSat      in   saturate select (COUNTER_SATURATE_EN only)
//   po_Count     out  registered count
//   po_bWrap     out  registered one-cycle wrap/clamp pulse
//   po_bAtMax    out  po_Count == MAX_VAL
//   po_bAtMin    out  po_Count == 0
// -----------------------------------------------------------------------------
module updown_counter_n #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             pi_bClk,
  input  logic             pi_bReset_n,
  input  logic             pi_bClear,
  input  logic             pi_bLoad,
  input  logic [WIDTH-1:0] pi_Data,
  input  logic             pi_bEnable,
  input  logic             pi_bUpDown,
  input  logic [WIDTH-1:0] pi_Step,
`ifdef COUNTER_SATURATE_EN
  input  logic             pi_bSat,
`endif
  output logic [WIDTH-1:0] po_Count,
  output logic             po_bWrap,
  output logic             po_bAtMax,
  output logic             po_bAtMin
);

  // Constants in the count width and in the one-bit-wider arithmetic width.
  // The modulus MAX_VAL+1 can be 2**WIDTH, so it only fits in WIDTH+1 bits.
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_X = MAX_X + 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] data_s;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   sum_x;
  logic             sat_mode;

  // Saturation is only selectable when the feature is compiled in.
`ifdef COUNTER_SATURATE_EN
  assign sat_mode = pi_bSat;
`else
  assign sat_mode = 1'b0;
`endif

  // Next-state computation. Priority is clear, then load, then an enabled
  // count, otherwise hold. The wrap pulse defaults to 0 so it is only ever
  // high for the single cycle following a boundary event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;

    step_s  = (pi_Step > MAX_W) ? MAX_W : pi_Step;
    data_s  = (pi_Data > MAX_W) ? MAX_W : pi_Data;
    step_x  = {1'b0, step_s};
    cnt_x   = {1'b0, count_q};
    // Both operands are <= MAX_VAL, so the sum cannot overflow WIDTH+1 bits.
    sum_x   = cnt_x + step_x;

    if (pi_bClear) begin
      count_d = RST_W;
    end else if (pi_bLoad) begin
      count_d = data_s;
    end else if (pi_bEnable && (step_s != '0)) begin
      if (!pi_bUpDown) begin
        // Counting up: anything past MAX_VAL either wraps or clamps.
        if (sum_x > MAX_X) begin
          wrap_d = 1'b1;
          if (sat_mode) begin
            count_d = MAX_W;
          end else begin
            count_d = WIDTH'(sum_x - MOD_X);
          end
        end else begin
          count_d = WIDTH'(sum_x);
        end
      end else begin
        // Counting down: a step larger than the count crosses zero.
        if (step_x > cnt_x) begin
          wrap_d = 1'b1;
          if (sat_mode) begin
            count_d = '0;
          end else begin
            count_d = WIDTH'(cnt_x + MOD_X - step_x);
          end
        end else begin
          count_d = WIDTH'(cnt_x - step_x);
        end
      end
    end
  end

  // State registers; reset acts immediately without waiting for a clock edge.
  always_ff @(posedge pi_bClk or negedge pi_bReset_n) begin
    if (!pi_bReset_n) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal-count flags decode the count register directly, so they change
  // in the same cycle as po_Count.
  assign po_Count  = count_q;
  assign po_bWrap  = wrap_q;
  assign po_bAtMax = (count_q == MAX_W);
  assign po_bAtMin = (count_q == '0);

endmodule
